apb_master_arb: RTL and testbench
=================================

Name: apb_master_arb

Overview:
- Round-robin arbiter and sequencer that shares one APB master port between NUM_REQ on-chip requesters, e.g. CPU shim, DMA and debug access into the i2c_master register block.
- Accepts one command per grant, runs a full SETUP/ACCESS APB transfer, and returns read data or an error to the winning requester.
- Bus abort by watchdog when the slave never asserts pready.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- AW, 32, paddr width
- DW, 32, pwdata/prdata width
- TIMEOUT, 256, max ACCESS cycles waiting for pready before abort (>=2)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  per-requester command valid
- req_write  in  NUM_REQ  1=write, 0=read
- req_addr  in  NUM_REQ*AW  packed addresses, requester i at [i*AW +: AW]
- req_wdata  in  NUM_REQ*DW  packed write data
- req_ready  out  NUM_REQ  one-hot accept pulse
- rsp_valid  out  NUM_REQ  one-hot completion pulse
- rsp_rdata  out  DW  read data, valid with rsp_valid
- rsp_err  out  1  1=timeout abort, valid with rsp_valid
- psel  out  1  APB select
- pen  out  1  APB enable
- pwrite  out  1  APB direction
- paddr  out  AW  APB address
- pwdata  out  DW  APB write data
- pready  in  1  APB ready
- prdata  in  DW  APB read data

Behaviour:
- Reset (sync, any state incl. mid-transfer): all outputs 0, state IDLE, RR pointer 0 (requester 0 highest priority), watchdog 0. Aborted transfer gets no response.
- States: IDLE, SETUP, ACCESS.
- IDLE: if any req_valid, pick winner = first set bit at or after pointer, wrapping. req_ready[winner]=1 this cycle (combinational from state+req_valid+pointer, one-hot). Latch write/addr/wdata/index, pointer <= winner+1 mod NUM_REQ, go SETUP. No valid: stay; outputs idle.
- Requester holds valid and fields stable until req_ready. Dropping valid before grant is legal: no grant, no response.
- SETUP (1 cycle): psel=1, pen=0, paddr/pwrite latched, pwdata=latched wdata for writes, 0 for reads. Go ACCESS.
- ACCESS: psel=1, pen=1, address/data held. Watchdog increments each cycle.
  - pready=1 at clk edge: rsp_valid[idx]=1 for next cycle, rsp_rdata=prdata for reads, 0 for writes, rsp_err=0. psel/pen/pwrite/paddr/pwdata <= 0, go IDLE.
  - Watchdog reaches TIMEOUT-1 with pready=0: same exit but rsp_err=1, rsp_rdata=0.
  - pready and timeout on the same cycle: pready wins.
- APB outputs and rsp_* registered. rsp_valid is a 1-cycle pulse coinciding with the IDLE cycle after ACCESS.
- Minimum transfer: grant (IDLE) + SETUP + 1 ACCESS = 3 cycles. Back-to-back transfers separated by exactly one IDLE cycle, which also grants the next requester.
- A requester may reassert valid the cycle of its own rsp_valid. It is eligible but RR-ordered.
- rsp_rdata/rsp_err hold last value between pulses.

Decomposition:
- Package apb_arb_pkg: state enum (IDLE, SETUP, ACCESS), function clog2-based WD_W width, index type width.
- Sub-module rr_arbiter: NUM_REQ request vector + pointer in, one-hot grant + encoded index out; purely combinational.

Test Plan:
- Single write from req 1, addr 0x10, data 0xA5, pready tied 1 -> req_ready[1] cycle 0; psel=1/pen=0 cycle 1; pen=1 cycle 2; rsp_valid[1], rsp_err=0 cycle 3.
- Read from req 0, pready after 5 ACCESS cycles, prdata=0xDEADBEEF -> pen high 5 cycles; rsp_rdata=0xDEADBEEF; pwdata=0 throughout.
- All four requests asserted from reset, held until granted -> grant order 0,1,2,3. Each transfer 3 cycles apart, APB never idle more than 1 cycle.
- Fairness: after grant to 2, reqs 1 and 3 pending -> 3 granted before 1.
- pready held 0, TIMEOUT=8 -> ACCESS lasts 8 cycles, then psel/pen drop; rsp_err=1, rsp_rdata=0. Pready on the 8th cycle instead -> rsp_err=0.
- rst asserted in ACCESS -> next cycle all outputs 0, no rsp_valid. Following request from req 3 with req 0 also pending -> req 0 granted first.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// Shared types and width helpers for the APB master arbiter.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  // Watchdog width: must be able to hold TIMEOUT-1.
  function automatic int wd_width(input int timeout);
    return (timeout > 2) ? $clog2(timeout) : 1;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx,
  output logic               any
);

  int          pos;
  logic [IW-1:0] pos_idx;

  // Scan from the farthest candidate back to ptr so the nearest one wins.
  always_comb begin
    grant   = '0;
    idx     = '0;
    any     = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos = int'(ptr) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      pos_idx = IW'(pos);
      if (req[pos_idx]) begin
        grant          = '0;
        grant[pos_idx] = 1'b1;
        idx            = pos_idx;
        any            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_master_arb.sv
// Shares one APB master port among NUM_REQ requesters with round-robin
// grants, a SETUP/ACCESS sequencer and a pready watchdog.
module apb_master_arb
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [DW-1:0]         rsp_rdata,
  output logic                  rsp_err,
  output logic                  psel,
  output logic                  pen,
  output logic                  pwrite,
  output logic [AW-1:0]         paddr,
  output logic [DW-1:0]         pwdata,
  input  logic                  pready,
  input  logic [DW-1:0]         prdata
);

  localparam int IW   = idx_width(NUM_REQ);
  localparam int WD_W = wd_width(TIMEOUT);

  state_t          state_reg, state_next;
  logic [IW-1:0]   ptr_reg;
  logic [IW-1:0]   idx_reg;
  logic [WD_W-1:0] wd_reg;

  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      win_idx;
  logic               win_any;
  logic               done_ok, done_to;

  logic [AW-1:0] addr_arr  [NUM_REQ];
  logic [DW-1:0] wdata_arr [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*AW +: AW];
      assign wdata_arr[gi] = req_wdata[gi*DW +: DW];
    end
  endgenerate

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_arb (
    .req   (req_valid),
    .ptr   (ptr_reg),
    .grant (grant),
    .idx   (win_idx),
    .any   (win_any)
  );

  // pready is checked before the watchdog so a late ready still completes.
  always_comb begin
    state_next = state_reg;
    req_ready  = '0;
    done_ok    = 1'b0;
    done_to    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (win_any && !rst) begin
          req_ready  = grant;
          state_next = SETUP;
        end
      end
      SETUP: state_next = ACCESS;
      ACCESS: begin
        if (pready) begin
          done_ok    = 1'b1;
          state_next = IDLE;
        end else if (wd_reg == WD_W'(TIMEOUT - 1)) begin
          done_to    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      idx_reg   <= '0;
      wd_reg    <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      psel      <= 1'b0;
      pen       <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
    end else begin
      state_reg <= state_next;
      rsp_valid <= '0;
      case (state_reg)
        IDLE: begin
          if (win_any) begin
            ptr_reg <= (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
            idx_reg <= win_idx;
            wd_reg  <= '0;
            psel    <= 1'b1;
            pen     <= 1'b0;
            pwrite  <= req_write[win_idx];
            paddr   <= addr_arr[win_idx];
            pwdata  <= req_write[win_idx] ? wdata_arr[win_idx] : '0;
          end
        end
        SETUP: pen <= 1'b1;
        ACCESS: begin
          if (done_ok || done_to) begin
            psel               <= 1'b0;
            pen                <= 1'b0;
            pwrite             <= 1'b0;
            paddr              <= '0;
            pwdata             <= '0;
            wd_reg             <= '0;
            rsp_valid[idx_reg] <= 1'b1;
            rsp_err            <= done_to;
            rsp_rdata          <= (done_ok && !pwrite) ? prdata : '0;
          end else begin
            wd_reg <= wd_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_arb.sv
// Self-checking bench for apb_master_arb: table vectors, directed sequences
// and a randomized run against a timestamp-based transaction model.
module tb_apb_master_arb;

  localparam int N   = 4;
  localparam int TMO = 8;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid, req_write;
  logic [N*32-1:0] req_addr, req_wdata;
  logic [N-1:0]   req_ready, rsp_valid;
  logic [31:0]    rsp_rdata;
  logic           rsp_err;
  logic           psel, pen, pwrite;
  logic [31:0]    paddr, pwdata;
  logic           pready;
  logic [31:0]    prdata;

  apb_master_arb #(.NUM_REQ(N), .AW(32), .DW(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .pen(pen), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .prdata(prdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  // Requester-side model state
  logic [N-1:0] pend;
  logic [N-1:0] wr_m;
  logic [31:0]  addr_m [N];
  logic [31:0]  wdata_m [N];
  int           lat_m [N];
  int           ptr_m;

  // In-flight transfer, described by its grant cycle and ready latency
  bit          act;
  int          g, lat, aidx;
  logic        awr;
  logic [31:0] aaddr, awdata, prd_at;
  logic [31:0] last_rdata;
  logic        last_err;

  bit          fixed_prd_en;
  logic [31:0] fixed_prd;
  bit          obs_rsp;
  logic [31:0] obs_rdata;
  logic        obs_err;
  int          obs_rsp_cyc;
  int          pen_cnt;
  int          glog_idx[$];
  int          glog_cyc[$];

  typedef struct {
    int          idx;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] prd;
    bit          exp_err;
    logic [31:0] exp_rdata;
    int          exp_pen;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
  endtask

  task automatic set_req(input int i, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input int l);
    pend[i] = 1'b1; wr_m[i] = wr; addr_m[i] = a; wdata_m[i] = d; lat_m[i] = l;
  endtask

  // One clock cycle: drive, sample #1 later, check against the model, advance.
  task automatic tick();
    int e, w, p;
    logic [N-1:0] exp_rv, exp_rr;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = pend[i];
      req_write[i] = wr_m[i];
      req_addr[i*32 +: 32]  = addr_m[i];
      req_wdata[i*32 +: 32] = wdata_m[i];
    end
    prdata = fixed_prd_en ? fixed_prd : $urandom;
    if (act && cyc >= g + 2) pready = (cyc == g + 1 + lat);
    else pready = 1'($urandom_range(0, 1));
    if (act && cyc == g + 1 + lat) prd_at = prdata;
    #1;
    if (rsp_valid != '0) begin
      obs_rsp = 1'b1; obs_rdata = rsp_rdata; obs_err = rsp_err; obs_rsp_cyc = cyc;
    end
    if (pen) pen_cnt++;
    if (rst) begin
      act = 1'b0; ptr_m = 0; last_rdata = '0; last_err = 1'b0;
    end else begin
      exp_rv = '0;
      if (act) begin
        e = g + 2 + ((lat < TMO) ? lat : TMO);
        if (cyc == e) begin
          exp_rv     = N'(1 << aidx);
          last_err   = (lat > TMO);
          last_rdata = (awr || lat > TMO) ? 32'h0 : prd_at;
          act        = 1'b0;
          $display("txn req=%0d wr=%0d addr=%0h err=%0d rdata=%0h cyc=%0d",
                   aidx, awr, aaddr, last_err, last_rdata, cyc);
        end
      end
      if (act)
        chk("apb_busy", 128'({psel, pen, pwrite, paddr, pwdata}),
            128'({1'b1, (cyc >= g + 2), awr, aaddr, (awr ? awdata : 32'h0)}));
      else
        chk("apb_idle", 128'({psel, pen, pwrite, paddr, pwdata}), 128'(0));
      chk("rsp", 128'({rsp_valid, rsp_err, rsp_rdata}), 128'({exp_rv, last_err, last_rdata}));
      exp_rr = '0;
      if (!act) begin
        w = -1;
        for (int k = 0; k < N; k++) begin
          p = (ptr_m + k) % N;
          if (w < 0 && pend[p]) w = p;
        end
        if (w >= 0) begin
          exp_rr = N'(1 << w);
          act = 1'b1; g = cyc; lat = lat_m[w]; aidx = w;
          awr = wr_m[w]; aaddr = addr_m[w]; awdata = wdata_m[w];
          pend[w] = 1'b0;
          ptr_m = (w + 1) % N;
          glog_idx.push_back(w);
          glog_cyc.push_back(cyc);
        end
      end
      chk("req_ready", 128'(req_ready), 128'(exp_rr));
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    pend = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pend = '0; wr_m = '0; ptr_m = 0; act = 1'b0;
    g = 0; lat = 0; aidx = 0; awr = 1'b0; aaddr = '0; awdata = '0; prd_at = '0;
    last_rdata = '0; last_err = 1'b0; fixed_prd_en = 1'b0; fixed_prd = '0;
    obs_rsp = 1'b0; obs_rdata = '0; obs_err = 1'b0; obs_rsp_cyc = 0; pen_cnt = 0;
    for (int i = 0; i < N; i++) begin
      addr_m[i] = '0; wdata_m[i] = '0; lat_m[i] = 1;
    end
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    pready = 1'b0; prdata = '0;

    vecs[0] = '{1, 1'b1, 32'h10, 32'hA5,   1, 32'h1234_5678, 1'b0, 32'h0,         1};
    vecs[1] = '{0, 1'b0, 32'h20, 32'h0,    5, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 5};
    vecs[2] = '{2, 1'b0, 32'h30, 32'h0,    9, 32'hCAFE_F00D, 1'b1, 32'h0,         8};
    vecs[3] = '{3, 1'b0, 32'h34, 32'h0,    8, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 8};
    vecs[4] = '{1, 1'b1, 32'h3C, 32'h55AA, 9, 32'h0000_1111, 1'b1, 32'h0,         8};
    vecs[5] = '{2, 1'b0, 32'h40, 32'h0,    2, 32'h7777_0001, 1'b0, 32'h7777_0001, 2};

    do_reset();
    tick();  // idle cycle straight after reset: everything at zero

    // Single transfers from the table
    fixed_prd_en = 1'b1;
    for (int v = 0; v < 6; v++) begin
      int g0;
      set_req(vecs[v].idx, vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].lat);
      fixed_prd = vecs[v].prd;
      obs_rsp = 1'b0; pen_cnt = 0; g0 = cyc;
      for (int t = 0; t < 40 && !obs_rsp; t++) tick();
      chk("vec_done", 128'(obs_rsp), 128'(1));
      chk("vec_err", 128'(obs_err), 128'(vecs[v].exp_err));
      chk("vec_rdata", 128'(obs_rdata), 128'(vecs[v].exp_rdata));
      chk("vec_pen_cycles", 128'(pen_cnt), 128'(vecs[v].exp_pen));
      chk("vec_latency", 128'(obs_rsp_cyc - g0), 128'(2 + vecs[v].exp_pen));
    end
    fixed_prd_en = 1'b0;

    // All four requesting from reset: order 0,1,2,3, grants 3 cycles apart
    do_reset();
    glog_idx.delete(); glog_cyc.delete();
    for (int i = 0; i < N; i++) set_req(i, i[0], 32'h100 + 32'(i * 4), 32'h50 + 32'(i), 1);
    for (int t = 0; t < 14; t++) tick();
    chk("rr_count", 128'(glog_idx.size() >= 4), 128'(1));
    for (int k = 0; k < 4; k++) chk("rr_order", 128'(glog_idx[k]), 128'(k));
    for (int k = 1; k < 4; k++) chk("rr_spacing", 128'(glog_cyc[k] - glog_cyc[k-1]), 128'(3));

    // Fairness: after 2 is granted, 3 goes before 1
    do_reset();
    glog_idx.delete(); glog_cyc.delete();
    set_req(2, 1'b0, 32'h200, 32'h0, 2);
    tick();
    set_req(1, 1'b1, 32'h204, 32'h11, 1);
    set_req(3, 1'b0, 32'h208, 32'h0, 1);
    for (int t = 0; t < 20; t++) tick();
    chk("fair_first", 128'(glog_idx[0]), 128'(2));
    chk("fair_second", 128'(glog_idx[1]), 128'(3));
    chk("fair_third", 128'(glog_idx[2]), 128'(1));

    // Reset during ACCESS: bus drops, no response, pointer back to 0
    do_reset();
    set_req(1, 1'b0, 32'h300, 32'h0, 20);
    for (int t = 0; t < 4; t++) tick();
    chk("mid_access", 128'({psel, pen}), 128'(2'b11));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_outputs", 128'({rsp_valid, rsp_err, rsp_rdata, psel, pen, pwrite, paddr, pwdata}), 128'(0));
    glog_idx.delete(); glog_cyc.delete();
    set_req(3, 1'b1, 32'h304, 32'h33, 1);
    set_req(0, 1'b0, 32'h308, 32'h0, 1);
    for (int t = 0; t < 10; t++) tick();
    chk("post_rst_first", 128'(glog_idx[0]), 128'(0));
    chk("post_rst_second", 128'(glog_idx[1]), 128'(3));

    // Randomized traffic
    do_reset();
    for (int t = 0; t < 1500; t++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 3) == 0)
          set_req(i, 1'($urandom_range(0, 1)), $urandom, $urandom, int'($urandom_range(1, 10)));
      tick();
    end
    for (int t = 0; t < 200 && (pend != '0 || act); t++) tick();
    chk("drained", 128'({pend, act}), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
